// File: rtl/cpu_pkg.sv
// Shared constants and types for the sequential Booth multiplier.
package cpu_pkg;

   localparam int WIDTH_DEF = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } mul_state_t;

   // Booth pair {Qreg[0], q_1}; 00 and 11 leave A untouched.
   localparam logic [1:0] BOOTH_SUB = 2'b10;
   localparam logic [1:0] BOOTH_ADD = 2'b01;

endpackage

// File: rtl/booth_mul_seq_if.sv
// Operand/result bundle for booth_mul_seq. MUL_OVF_EN adds the ovf result bit.
interface booth_mul_seq_if #(
   parameter int WIDTH = cpu_pkg::WIDTH_DEF
);
   // start is sampled on each rising edge; it is accepted only while busy is low
   // (IDLE or FINISH) and is dropped, not queued, while busy is high. done pulses
   // for one cycle when MR/ACC_NUM carry a new product; busy and done never overlap.
   logic             start;
   logic [WIDTH-1:0] multiplicand;
   logic [WIDTH-1:0] multiplier;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] MR;
   logic [WIDTH-1:0] ACC_NUM;
`ifdef MUL_OVF_EN
   logic             ovf;

   modport master (output start, multiplicand, multiplier,
                   input  busy, done, MR, ACC_NUM, ovf);
   modport slave  (input  start, multiplicand, multiplier,
                   output busy, done, MR, ACC_NUM, ovf);
`else
   modport master (output start, multiplicand, multiplier,
                   input  busy, done, MR, ACC_NUM);
   modport slave  (input  start, multiplicand, multiplier,
                   output busy, done, MR, ACC_NUM);
`endif

endinterface

// File: rtl/booth_mul_seq_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then an
// arithmetic right shift of {A, Qreg, q_1}.
module booth_step
   import cpu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH:0]   a_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic             q1_i,
   input  logic [WIDTH:0]   m_i,
   output logic [WIDTH:0]   a_o,
   output logic [WIDTH-1:0] q_o,
   output logic             q1_o
);

   logic [WIDTH:0] sum;

   always_comb begin
      sum = a_i;
      case ({q_i[0], q1_i})
         BOOTH_SUB: sum = a_i - m_i;
         BOOTH_ADD: sum = a_i + m_i;
         default:   sum = a_i;
      endcase
      // The old q_1 falls off the bottom; A's sign bit is replicated at the top.
      {a_o, q_o, q1_o} = {sum[WIDTH], sum, q_i};
   end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier: WIDTH steps per product, result split
// into MR (high half) and ACC_NUM (low half). MUL_OVF_EN adds a registered ovf flag.
module booth_mul_seq
   import cpu_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   booth_mul_seq_if.slave bus,
   output mul_state_t state_dbg_o
);

   localparam int CW = $clog2(WIDTH);

   mul_state_t       state_q, state_d;
   logic [WIDTH:0]   a_q, m_q;
   logic [WIDTH-1:0] q_q;
   logic             q1_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] mr_q, acc_q;

   logic [WIDTH:0]   step_a;
   logic [WIDTH-1:0] step_q;
   logic             step_q1;
   logic             start_acc;
   logic             last_step;

   assign start_acc = bus.start && (state_q != RUN);
   assign last_step = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));

   booth_step #(.WIDTH(WIDTH)) u_step (
      .a_i  (a_q),
      .q_i  (q_q),
      .q1_i (q1_q),
      .m_i  (m_q),
      .a_o  (step_a),
      .q_o  (step_q),
      .q1_o (step_q1)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_acc) state_d = RUN;
         RUN:     if (last_step) state_d = FINISH;
         FINISH:  state_d = start_acc ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state_q == RUN);
      bus.done = (state_q == FINISH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         m_q   <= '0;
         q_q   <= '0;
         q1_q  <= 1'b0;
         cnt_q <= '0;
         mr_q  <= '0;
         acc_q <= '0;
      end else if (start_acc) begin
         a_q   <= '0;
         m_q   <= {bus.multiplicand[WIDTH-1], bus.multiplicand};
         q_q   <= bus.multiplier;
         q1_q  <= 1'b0;
         cnt_q <= '0;
      end else if (state_q == RUN) begin
         a_q   <= step_a;
         q_q   <= step_q;
         q1_q  <= step_q1;
         cnt_q <= cnt_q + 1'b1;
         // Outputs move only here, so partial products never reach the display.
         if (last_step) begin
            mr_q  <= step_a[WIDTH-1:0];
            acc_q <= step_q;
         end
      end
   end

`ifdef MUL_OVF_EN
   logic ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         ovf_q <= 1'b0;
      else if (last_step) ovf_q <= (step_a[WIDTH-1:0] != {WIDTH{step_q[WIDTH-1]}});
   end

   assign bus.ovf = ovf_q;
`endif

   assign bus.MR      = mr_q;
   assign bus.ACC_NUM = acc_q;
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq; ovf checks are included when MUL_OVF_EN is defined.
module tb_booth_mul_seq;
   import cpu_pkg::*;

   localparam int W = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   mul_state_t state_dbg;

   booth_mul_seq_if #(.WIDTH(W)) bus ();

   booth_mul_seq #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .state_dbg_o (state_dbg)
   );

   always #5 clk = ~clk;

   logic [2*W-1:0] exp_q[$];
   int vectors = 0;
   int miscompares = 0;

   function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [2*W-1:0] p;
      p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
      return p;
   endfunction

`ifdef MUL_OVF_EN
   function automatic logic ovf_of(input logic [2*W-1:0] p);
      logic [W:0] top;
      top = p[2*W-1:W-1];
      return (top != '0) && (top != '1);
   endfunction
`endif

   function automatic logic [2*W-1:0] pop_exp();
      if (exp_q.size() == 0) return 'x;
      return exp_q.pop_front();
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents operands with start for exactly one edge (the accepting edge E0).
   task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_it);
      bus.multiplicand = a;
      bus.multiplier   = b;
      bus.start        = 1'b1;
      if (expect_it) exp_q.push_back(model(a, b));
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output bit seen);
      cyc  = 0;
      seen = 1'b0;
      while (cyc < 40 && !seen) begin
         tick();
         cyc++;
         if (bus.done === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      bus.start        = 1'b0;
      bus.multiplicand = '0;
      bus.multiplier   = '0;
      rst_n            = 1'b0;
      repeat (2) tick();
      vectors++;
      if ({bus.MR, bus.ACC_NUM} !== '0) begin
         miscompares++;
         $display("FAIL reset_product: got %h want 0", {bus.MR, bus.ACC_NUM});
      end
      vectors++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_flags: busy=%b done=%b want 0 0", bus.busy, bus.done);
      end
      vectors++;
      if (state_dbg !== IDLE) begin
         miscompares++;
         $display("FAIL reset_state: got %0d want %0d", state_dbg, IDLE);
      end
`ifdef MUL_OVF_EN
      vectors++;
      if (bus.ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ovf: got %b want 0", bus.ovf);
      end
`endif
      @(negedge clk) rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int busy_cnt;
      logic [2*W-1:0] e;
      drive_start(16'd3, 16'd5, 1'b1);
      busy_cnt = (bus.busy === 1'b1 && bus.done === 1'b0) ? 1 : 0;
      for (int i = 1; i < 16; i++) begin
         tick();
         if (bus.busy === 1'b1 && bus.done === 1'b0) busy_cnt++;
      end
      vectors++;
      if (busy_cnt != 16) begin
         miscompares++;
         $display("FAIL basic_busy_cycles: got %0d want 16", busy_cnt);
      end
      tick();
      vectors++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_done_e16: done=%b busy=%b want 1 0", bus.done, bus.busy);
      end
      e = pop_exp();
      vectors++;
      if ({bus.MR, bus.ACC_NUM} !== e) begin
         miscompares++;
         $display("FAIL basic_product: got %h want %h", {bus.MR, bus.ACC_NUM}, e);
      end
      tick();
      vectors++;
      if (bus.done !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_done_e17: got %b want 0", bus.done);
      end
   endtask

   task automatic test_signed();
      logic [W-1:0] ta[6] = '{16'hFFF9, 16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h8000};
      logic [W-1:0] tb[6] = '{16'h0006, 16'h8000, 16'h8000, 16'hFFFF, 16'hFFFF, 16'h0001};
      logic [W-1:0] a, b;
      logic [2*W-1:0] e;
      int cyc;
      bit seen;
      for (int i = 0; i < 12; i++) begin
         if (i < 6) begin
            a = ta[i];
            b = tb[i];
         end else begin
            a = W'($urandom_range(0, 16'hFFFF));
            b = W'($urandom_range(0, 16'hFFFF));
         end
         drive_start(a, b, 1'b1);
         wait_done(cyc, seen);
         e = pop_exp();
         vectors++;
         if (!seen || cyc != 16) begin
            miscompares++;
            $display("FAIL signed_latency %h*%h: got %0d cycles (seen=%b) want 16", a, b, cyc, seen);
         end
         vectors++;
         if ({bus.MR, bus.ACC_NUM} !== e) begin
            miscompares++;
            $display("FAIL signed_product %h*%h: got %h want %h", a, b, {bus.MR, bus.ACC_NUM}, e);
         end
`ifdef MUL_OVF_EN
         vectors++;
         if (bus.ovf !== ovf_of(e)) begin
            miscompares++;
            $display("FAIL signed_ovf %h*%h: got %b want %b", a, b, bus.ovf, ovf_of(e));
         end
`endif
         tick();
      end
   endtask

   task automatic test_ignore_restart();
      logic [2*W-1:0] e;
      int cyc;
      bit seen;
      drive_start(16'd1234, 16'hFFC8, 1'b1);
      repeat (4) tick();
      bus.multiplicand = 16'h7FFF;
      bus.multiplier   = 16'h7FFF;
      bus.start        = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_done(cyc, seen);
      e = pop_exp();
      vectors++;
      if (!seen || cyc != 11) begin
         miscompares++;
         $display("FAIL restart_latency: got %0d cycles after restart (seen=%b) want 11", cyc, seen);
      end
      vectors++;
      if ({bus.MR, bus.ACC_NUM} !== e) begin
         miscompares++;
         $display("FAIL restart_product: got %h want %h", {bus.MR, bus.ACC_NUM}, e);
      end
      tick();
      vectors++;
      if (bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL restart_not_requeued: busy=%b want 0", bus.busy);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [2*W-1:0] e;
      int cyc;
      int dn;
      bit seen;
      drive_start(16'd300, 16'hFF38, 1'b0);
      repeat (7) tick();
      rst_n = 1'b0;
      #2;
      vectors++;
      if ({bus.MR, bus.ACC_NUM} !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_outputs: prod=%h busy=%b done=%b want 0 0 0",
                  {bus.MR, bus.ACC_NUM}, bus.busy, bus.done);
      end
      vectors++;
      if (state_dbg !== IDLE) begin
         miscompares++;
         $display("FAIL midreset_state: got %0d want %0d", state_dbg, IDLE);
      end
      @(negedge clk) rst_n = 1'b1;
      dn = 0;
      repeat (20) begin
         tick();
         if (bus.done !== 1'b0) dn++;
      end
      vectors++;
      if (dn != 0) begin
         miscompares++;
         $display("FAIL midreset_no_done: got %0d done cycles want 0", dn);
      end
      drive_start(16'd2, 16'd2, 1'b1);
      wait_done(cyc, seen);
      e = pop_exp();
      vectors++;
      if (!seen || {bus.MR, bus.ACC_NUM} !== e) begin
         miscompares++;
         $display("FAIL midreset_followup: got %h (seen=%b) want %h", {bus.MR, bus.ACC_NUM}, seen, e);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [2*W-1:0] e1, e2;
      int cyc;
      bit seen;
      bus.multiplicand = 16'd100;
      bus.multiplier   = 16'd100;
      bus.start        = 1'b1;
      exp_q.push_back(model(16'd100, 16'd100));
      tick();
      bus.multiplicand = 16'hFFFF;
      bus.multiplier   = 16'h0001;
      exp_q.push_back(model(16'hFFFF, 16'h0001));
      wait_done(cyc, seen);
      e1 = pop_exp();
      vectors++;
      if (!seen || cyc != 16 || {bus.MR, bus.ACC_NUM} !== e1) begin
         miscompares++;
         $display("FAIL b2b_first: got %h after %0d cycles (seen=%b) want %h after 16",
                  {bus.MR, bus.ACC_NUM}, cyc, seen, e1);
      end
      tick();
      vectors++;
      if (bus.busy !== 1'b1 || {bus.MR, bus.ACC_NUM} !== e1) begin
         miscompares++;
         $display("FAIL b2b_hold: busy=%b prod=%h want 1 %h", bus.busy, {bus.MR, bus.ACC_NUM}, e1);
      end
      wait_done(cyc, seen);
      bus.start = 1'b0;
      e2 = pop_exp();
      vectors++;
      if (!seen || cyc + 1 != 17 || {bus.MR, bus.ACC_NUM} !== e2) begin
         miscompares++;
         $display("FAIL b2b_second: got %h after %0d cycles (seen=%b) want %h after 17",
                  {bus.MR, bus.ACC_NUM}, cyc + 1, seen, e2);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signed();
      test_ignore_restart();
      test_reset_mid_run();
      test_back_to_back();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
